// File: rtl/demux4_buf.sv
// 1-to-4 demultiplexer with a one-entry valid/ready output register per channel.
// Counts blocked producer cycles in a saturating 8-bit overflow counter.
module demux4_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [4*WIDTH-1:0] out_data,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic [7:0]         overflow_cnt
);

  logic [WIDTH-1:0] data_q [4];
  logic [WIDTH-1:0] data_d [4];
  logic [3:0]       valid_q, valid_d;
  logic [7:0]       ovf_q, ovf_d;
  logic [3:0]       drain;
  logic             accept;

  assign drain    = valid_q & out_ready;
  // Only the addressed channel gates the producer.
  assign in_ready = ~valid_q[in_sel] | out_ready[in_sel];
  assign accept   = in_valid & in_ready;

  always_comb begin
    valid_d = valid_q;
    ovf_d   = ovf_q;
    for (int unsigned n = 0; n < 4; n++) begin
      data_d[n] = data_q[n];
      // A same-cycle accept overrides a drain, keeping the channel at full throughput.
      if (accept && (in_sel == 2'(n))) begin
        data_d[n]  = in_data;
        valid_d[n] = 1'b1;
      end else if (drain[n]) begin
        valid_d[n] = 1'b0;
      end
    end
    if (in_valid && !in_ready && (ovf_q != 8'hff)) begin
      ovf_d = ovf_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      ovf_q   <= '0;
      for (int unsigned n = 0; n < 4; n++) begin
        data_q[n] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      for (int unsigned n = 0; n < 4; n++) begin
        data_q[n] <= data_d[n];
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int unsigned n = 0; n < 4; n++) begin
      out_data[n*WIDTH +: WIDTH] = data_q[n];
    end
  end

  assign out_valid    = valid_q;
  assign overflow_cnt = ovf_q;

endmodule

// File: doc/demux4_buf.md
Name: demux4_buf

Overview:
- 1-to-4 demultiplexer: the receive-side counterpart of the 4:1 MUX.
- Takes one input word plus a 2-bit select and routes it to one of four output channels.
- Each channel has a one-entry output register with valid/ready flow control, so four independent consumers can drain at their own pace.
- Sits between a single producer (datapath or bus master) and four sinks (register-file write ports, peripherals).

Parameters:
WIDTH, 8, data width of the input word and of each output channel.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
in_data  input  WIDTH  word to route.
in_sel  input  2  destination channel: 0=A, 1=B, 2=C, 3=D. Sampled only when in_valid=1.
in_valid  input  1  producer has a word this cycle.
in_ready  output  1  demux can accept the word addressed by in_sel this cycle.
out_data  output  4*WIDTH  channel n occupies bits [n*WIDTH +: WIDTH].
out_valid  output  4  bit n = channel n register holds an undelivered word.
out_ready  input  4  bit n = consumer n takes the word this cycle.
overflow_cnt  output  8  count of cycles where in_valid=1 and in_ready=0; saturates at 255.

Behaviour:
- Reset (rst=1 at clk edge): out_valid=0, all out_data=0, overflow_cnt=0. Any pending words are discarded. in_ready follows its combinational equation, so it reads 1 during and after reset.
- Per-channel drain: drain[n] = out_valid[n] & out_ready[n].
- Accept:
  - in_ready = ~out_valid[in_sel] | out_ready[in_sel]. This is combinational and depends only on the addressed channel.
  - accept = in_valid & in_ready.
- On accept:
  - reg[in_sel] <= in_data; out_valid[in_sel] <= 1.
  - Latency is 1 cycle: the word appears on out_data the cycle after acceptance.
- Channel n not addressed, or no accept:
  - if drain[n]: out_valid[n] <= 0, and data holds its last value.
  - otherwise the channel is unchanged.
- Simultaneous drain and accept on the same channel: the new word replaces the old one and out_valid stays 1. This gives full throughput of one word per cycle per channel.
- Simultaneous drain on channel m and accept on channel n (m≠n): both happen independently.
- All four channels may drain in the same cycle.
- Stability: while out_valid[n]=1 and out_ready[n]=0, out_data[n] and out_valid[n] must not change.
- No accept occurs while in_valid=0. in_sel and in_data are ignored when in_valid=0, including X values.
- Blocked input: if in_valid=1 and in_ready=0, no state changes except overflow_cnt. overflow_cnt increments by 1, saturating at 255 and never wrapping to 0. The producer must hold its word until accepted.
- One word can be accepted per cycle. There is no reordering within a channel.
- Reset mid-operation takes priority over accept and drain in the same cycle.

Test Plan:
1. Reset, then in_data=8'h01, in_sel=0, in_valid=1 for 1 cycle, out_ready=4'b1111 -> next cycle out_valid=4'b0001, out_data[A]=8'h01; one cycle later out_valid=0.
2. out_ready=0; send 8'hA0, 8'hB1, 8'hC2, 8'hD3 to sel 0,1,2,3 on consecutive cycles -> all accepted (in_ready=1), out_valid=4'b1111, out_data={D3,C2,B1,A0}, values stable for 10 cycles.
3. With channel B full and out_ready[B]=0, present 8'h55 with sel=1 for 3 cycles -> in_ready=0, channel B still holds B1, overflow_cnt=3. Then raise out_ready[B] -> 8'h55 accepted the same cycle and appears next cycle.
4. out_ready[C]=1 held while streaming 8'h10..8'h17 to sel=2 back-to-back -> in_ready stays 1, out_data[C] shows 10..17 on successive cycles with no bubbles.
5. Hold a blocked request for 300 cycles -> overflow_cnt reaches 255 and stays there.
6. Fill all channels, assert rst for 1 cycle with in_valid=1, sel=3 -> out_valid=0, out_data=0, overflow_cnt=0, and the word presented during the reset cycle is not captured.
